// File: rtl/fma_pkg.sv
// Shared widths for the FMA alignment stage: default operand sizes and the
// guard/round/sticky extension carried by aligned mantissas.
package fma_pkg;
    localparam int MW_DEF = 48;
    localparam int EW_DEF = 9;
    localparam int GRS_W  = 3;
    localparam int OPW    = 8;
    localparam int AW_DEF = MW_DEF + GRS_W;
endpackage

// File: rtl/fma_align_stage_if.sv
// Input/output beat bundle of the alignment stage; slave side is the stage,
// master side is whoever feeds and drains it.
interface fma_align_stage_if
    import fma_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
);
    localparam int AW = MW + GRS_W;

    logic           in_valid;
    logic           in_ready;
    logic [EW-1:0]  ab_exp;
    logic [EW-1:0]  cd_exp;
    logic [MW-1:0]  ab_man;
    logic [MW-1:0]  cd_man;
    logic           ab_sign;
    logic           cd_sign;
    logic [OPW-1:0] op_sel;
    logic           path_sel;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  big_man;
    logic [AW-1:0]  sml_man;
    logic [EW-1:0]  res_exp;
    logic           big_sign;
    logic           eff_sub;
    logic           swap;
    logic [OPW-1:0] op_sel_o;
    logic           path_o;

    modport master (
        output in_valid, ab_exp, cd_exp, ab_man, cd_man, ab_sign, cd_sign,
               op_sel, path_sel, out_ready,
        input  in_ready, out_valid, big_man, sml_man, res_exp, big_sign,
               eff_sub, swap, op_sel_o, path_o
    );

    modport slave (
        input  in_valid, ab_exp, cd_exp, ab_man, cd_man, ab_sign, cd_sign,
               op_sel, path_sel, out_ready,
        output in_ready, out_valid, big_man, sml_man, res_exp, big_sign,
               eff_sub, swap, op_sel_o, path_o
    );
endinterface

// File: rtl/fma_rshift_sticky.sv
// Right shift by sh_i with every shifted-out bit ORed into bit 0; shifts of
// W or more collapse the whole operand into the sticky bit.
module fma_rshift_sticky #(
    parameter int W  = 51,
    parameter int SW = 9
) (
    input  logic [W-1:0]  din_i,
    input  logic [SW-1:0] sh_i,
    output logic [W-1:0]  dout_o
);
    localparam logic [31:0] W_U = 32'(W);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;
    logic         sticky;
    logic         sat;

    assign sat       = 32'(sh_i) >= W_U;
    assign shifted   = din_i >> sh_i;
    assign lost_mask = ~({W{1'b1}} << sh_i);
    assign sticky    = |(din_i & lost_mask);
    assign dout_o    = sat ? {{(W-1){1'b0}}, |din_i}
                           : {shifted[W-1:1], shifted[0] | sticky};
endmodule

// File: rtl/fma_align_stage.sv
// FMA operand alignment: stage 1 orders the products by exponent sum,
// stage 2 right-shifts the smaller mantissa with G/R/S into the output register.
module fma_align_stage
    import fma_pkg::*;
#(
    parameter int MW = MW_DEF,
    parameter int EW = EW_DEF
) (
    input logic              clk,
    input logic              rst,
    fma_align_stage_if.slave bus
);
    localparam int AW = MW + GRS_W;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, in_ready, s1_load, s2_load;

    // Upstream sees ready whenever stage 1 is empty or will drain this cycle.
    assign s1_adv     = !s2_valid_q || bus.out_ready;
    assign in_ready   = !s1_valid_q || s1_adv;
    assign s1_load    = bus.in_valid && in_ready;
    assign s2_load    = s1_valid_q && s1_adv;
    assign s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
    assign s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;

    logic          swap_c;
    logic [EW-1:0] diff_c;
    assign swap_c = bus.cd_exp > bus.ab_exp;
    assign diff_c = swap_c ? bus.cd_exp - bus.ab_exp : bus.ab_exp - bus.cd_exp;

    logic [MW-1:0]  s1_big_q, s1_sml_q;
    logic [EW-1:0]  s1_diff_q, s1_exp_q;
    logic           s1_bsign_q, s1_esub_q, s1_swap_q, s1_path_q;
    logic [OPW-1:0] s1_op_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_big_q   <= '0;
            s1_sml_q   <= '0;
            s1_diff_q  <= '0;
            s1_exp_q   <= '0;
            s1_bsign_q <= 1'b0;
            s1_esub_q  <= 1'b0;
            s1_swap_q  <= 1'b0;
            s1_path_q  <= 1'b0;
            s1_op_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_big_q   <= swap_c ? bus.cd_man : bus.ab_man;
                s1_sml_q   <= swap_c ? bus.ab_man : bus.cd_man;
                s1_diff_q  <= diff_c;
                s1_exp_q   <= swap_c ? bus.cd_exp : bus.ab_exp;
                s1_bsign_q <= swap_c ? bus.cd_sign : bus.ab_sign;
                s1_esub_q  <= bus.ab_sign ^ bus.cd_sign;
                s1_swap_q  <= swap_c;
                s1_path_q  <= bus.path_sel;
                s1_op_q    <= bus.op_sel;
            end
        end
    end

    logic [AW-1:0] shf_out;

    fma_rshift_sticky #(.W(AW), .SW(EW)) u_shf (
        .din_i  ({s1_sml_q, {GRS_W{1'b0}}}),
        .sh_i   (s1_diff_q),
        .dout_o (shf_out)
    );

    logic [AW-1:0]  big_man_q, sml_man_q;
    logic [EW-1:0]  res_exp_q;
    logic           big_sign_q, eff_sub_q, swap_q, path_q;
    logic [OPW-1:0] op_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            big_man_q  <= '0;
            sml_man_q  <= '0;
            res_exp_q  <= '0;
            big_sign_q <= 1'b0;
            eff_sub_q  <= 1'b0;
            swap_q     <= 1'b0;
            path_q     <= 1'b0;
            op_sel_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                big_man_q  <= {s1_big_q, {GRS_W{1'b0}}};
                sml_man_q  <= shf_out;
                res_exp_q  <= s1_exp_q;
                big_sign_q <= s1_bsign_q;
                eff_sub_q  <= s1_esub_q;
                swap_q     <= s1_swap_q;
                path_q     <= s1_path_q;
                op_sel_q   <= s1_op_q;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.big_man   = big_man_q;
    assign bus.sml_man   = sml_man_q;
    assign bus.res_exp   = res_exp_q;
    assign bus.big_sign  = big_sign_q;
    assign bus.eff_sub   = eff_sub_q;
    assign bus.swap      = swap_q;
    assign bus.op_sel_o  = op_sel_q;
    assign bus.path_o    = path_q;
endmodule

// File: tb/tb_fma_align_stage.sv
// Directed-vector bench for fma_align_stage: single beats with hand-derived
// alignment results, a stalled burst, and reset with both stages occupied.
module tb_fma_align_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fma_align_stage_if bus ();

    fma_align_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [8:0] ae, input logic [8:0] ce,
                         input logic [47:0] am, input logic [47:0] cm,
                         input logic as, input logic cs,
                         input logic [7:0] op, input logic pth);
        bus.ab_exp   = ae;
        bus.cd_exp   = ce;
        bus.ab_man   = am;
        bus.cd_man   = cm;
        bus.ab_sign  = as;
        bus.cd_sign  = cs;
        bus.op_sel   = op;
        bus.path_sel = pth;
    endtask

    task automatic run_beat(input string tag,
                            input logic [8:0] ae, input logic [8:0] ce,
                            input logic [47:0] am, input logic [47:0] cm,
                            input logic as, input logic cs,
                            input logic [7:0] op, input logic pth,
                            input logic [50:0] e_big, input logic [50:0] e_sml,
                            input logic [8:0] e_res, input logic e_swap,
                            input logic e_bs, input logic e_es);
        int lat;
        @(negedge clk);
        drive(ae, ce, am, cm, as, cs, op, pth);
        bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, 2);
        chk({tag, ".big_man"}, bus.big_man, e_big);
        chk({tag, ".sml_man"}, bus.sml_man, e_sml);
        chk({tag, ".res_exp"}, bus.res_exp, e_res);
        chk({tag, ".swap"}, bus.swap, e_swap);
        chk({tag, ".big_sign"}, bus.big_sign, e_bs);
        chk({tag, ".eff_sub"}, bus.eff_sub, e_es);
        chk({tag, ".op_sel_o"}, bus.op_sel_o, op);
        chk({tag, ".path_o"}, bus.path_o, pth);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(9'd0, 9'd0, 48'h0, 48'h0, 1'b0, 1'b0, 8'h0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.in_ready", bus.in_ready, 1);
        chk("rst.big_man", bus.big_man, 0);
        chk("rst.sml_man", bus.sml_man, 0);
        chk("rst.res_exp", bus.res_exp, 0);

        run_beat("t1", 9'd254, 9'd250, 48'h800000000000, 48'h800000000000, 1'b0, 1'b0, 8'h11, 1'b0,
                 51'h4_0000_0000_0000, 51'h0_4000_0000_0000, 9'd254, 1'b0, 1'b0, 1'b0);
        run_beat("t2", 9'd100, 9'd300, 48'h000000000001, 48'hC00000000000, 1'b1, 1'b0, 8'h22, 1'b1,
                 51'h6_0000_0000_0000, 51'h1, 9'd300, 1'b1, 1'b0, 1'b1);
        run_beat("t3", 9'd127, 9'd127, 48'h900000000000, 48'h123456789ABC, 1'b0, 1'b1, 8'h33, 1'b1,
                 51'h4_8000_0000_0000, 51'h0_91A2_B3C4_D5E0, 9'd127, 1'b0, 1'b0, 1'b1);
        run_beat("t4", 9'd10, 9'd5, 48'h000000000001, 48'h00000000001F, 1'b1, 1'b1, 8'h44, 1'b0,
                 51'h8, 51'h7, 9'd10, 1'b0, 1'b1, 1'b0);
        run_beat("zero", 9'd20, 9'd3, 48'hFFFFFFFFFFFF, 48'h0, 1'b0, 1'b0, 8'h55, 1'b0,
                 51'h7_FFFF_FFFF_FFF8, 51'h0, 9'd20, 1'b0, 1'b0, 1'b0);
        run_beat("d49", 9'd100, 9'd51, 48'h000000000001, 48'hC00000000000, 1'b0, 1'b1, 8'h66, 1'b1,
                 51'h8, 51'h3, 9'd100, 1'b0, 1'b0, 1'b1);
        run_beat("d51", 9'd51, 9'd102, 48'h800000000000, 48'h000000000001, 1'b0, 1'b1, 8'h77, 1'b0,
                 51'h8, 51'h1, 9'd102, 1'b1, 1'b1, 1'b1);
        run_beat("emax", 9'd0, 9'd511, 48'h0, 48'h000000000001, 1'b1, 1'b0, 8'h88, 1'b0,
                 51'h8, 51'h0, 9'd511, 1'b1, 1'b0, 1'b1);

        // Burst of 8 with downstream stalled for three cycles.
        begin
            int tx = 0;
            int rx = 0;
            logic saw_stall = 1'b0;
            logic fire_in, fire_out;
            logic [50:0] e_sml;
            for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
                @(negedge clk);
                bus.out_ready = !(cyc >= 3 && cyc <= 5);
                bus.in_valid  = (tx < 8);
                drive(9'd100, 9'(100 - tx), 48'h800000000000, 48'h800000000000,
                      1'b0, 1'b0, 8'(tx), 1'b0);
                #1;
                if (bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
                fire_in  = bus.in_valid && bus.in_ready;
                fire_out = bus.out_valid && bus.out_ready;
                if (fire_out) begin
                    e_sml = 51'h4_0000_0000_0000;
                    e_sml = e_sml >> rx;
                    chk("burst.op_sel_o", bus.op_sel_o, 8'(rx));
                    chk("burst.sml_man", bus.sml_man, e_sml);
                    rx++;
                end
                @(posedge clk);
                if (fire_in) tx++;
            end
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            chk("burst.rx", rx, 8);
            chk("burst.tx", tx, 8);
            chk("burst.stall_seen", saw_stall, 1);
            repeat (3) @(negedge clk);
            chk("burst.no_dup", bus.out_valid, 0);
        end

        // Fill both stages, then reset.
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(9'd30, 9'd20, 48'h1, 48'h2, 1'b1, 1'b0, 8'hA1, 1'b1);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(9'd40, 9'd20, 48'h3, 48'h4, 1'b1, 1'b0, 8'hA2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("full.out_valid", bus.out_valid, 1);
        chk("full.in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("rst2.out_valid", bus.out_valid, 0);
        chk("rst2.in_ready", bus.in_ready, 1);
        chk("rst2.big_man", bus.big_man, 0);
        chk("rst2.sml_man", bus.sml_man, 0);
        chk("rst2.op_sel_o", bus.op_sel_o, 0);
        run_beat("post_rst", 9'd10, 9'd5, 48'h000000000001, 48'h00000000001F, 1'b1, 1'b1, 8'h44, 1'b0,
                 51'h8, 51'h7, 9'd10, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst.drained", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
